// File: rtl/tone_sequencer.sv
// tone_sequencer: plays timed note commands as a square-wave buzzer tone.
//   Each accepted note is followed by an articulation gap and a done pulse.
//   Optional macro TONE_SEQUENCER_VOLUME_EN adds a 3-bit PWM volume input.
// Ports:
//   ext_clk_25m / ext_rst          clock, asynchronous active-high reset
//   in_valid / in_ready            command handshake (accepted on valid && ready)
//   in_code / in_oct / in_dur      note code (0 = rest), octave raise, duration-1 in units
//   stop                           synchronous abort back to idle
//   vol (macro only)               PWM volume, 0 = mute, 7 = 7/8 duty
//   beep                           buzzer drive
//   cur_code / high                display info: sounding code, high-register flag
//   busy / note_done               activity flag, one-cycle completion pulse
module tone_sequencer #(
  parameter int unsigned CLK_HZ  = 25_000_000,
  parameter int unsigned UNIT_HZ = 16,
  parameter int unsigned DUR_W   = 4,
  parameter int unsigned OCT_W   = 2,
  parameter int unsigned GAP_CYC = 250_000,
  parameter int unsigned DIV_W   = 20
) (
  input  logic             ext_clk_25m,
  input  logic             ext_rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       in_code,
  input  logic [OCT_W-1:0] in_oct,
  input  logic [DUR_W-1:0] in_dur,
  input  logic             stop,
`ifdef TONE_SEQUENCER_VOLUME_EN
  input  logic [2:0]       vol,
`endif
  output logic             beep,
  output logic [3:0]       cur_code,
  output logic             high,
  output logic             busy,
  output logic             note_done
);

  localparam int unsigned UNIT_CYC  = CLK_HZ / UNIT_HZ;
  localparam int unsigned UNIT_LAST = (UNIT_CYC > 0) ? UNIT_CYC - 1 : 0;
  localparam int          UNIT_W    = (UNIT_CYC > 1) ? $clog2(UNIT_CYC) : 1;
  localparam bit          HAS_GAP   = (GAP_CYC != 0);
  localparam int unsigned GAP_LAST  = HAS_GAP ? GAP_CYC - 1 : 0;
  localparam int          GAP_W     = (GAP_CYC > 1) ? $clog2(GAP_CYC) : 1;

  // Note frequencies in Hz; index 0 is the rest code.
  localparam int unsigned FREQ_HZ [16] = '{
    0, 262, 294, 330, 349, 392, 440, 494,
    523, 587, 659, 698, 784, 880, 988, 1047
  };

  function automatic logic [DIV_W-1:0] half_for(input int unsigned f);
    return (f == 0) ? DIV_W'(1) : DIV_W'(CLK_HZ / (2 * f));
  endfunction

  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_PLAY, S_GAP} state_t;

  state_t           r_state;
  logic [3:0]       r_code;
  logic [OCT_W-1:0] r_oct;
  logic [DUR_W-1:0] r_dur;
  logic [DIV_W-1:0] r_half;
  logic [DIV_W-1:0] r_phase;
  logic [UNIT_W-1:0] r_unit;
  logic [DUR_W-1:0] r_beat;
  logic [GAP_W-1:0] r_gap;
  logic             r_tone;
  logic             r_ready;
  logic             r_busy;
  logic             r_done;
  logic             r_high;
  logic [3:0]       r_cur;

  // Half-period table is fixed at elaboration; only a 16-way mux remains.
  logic [DIV_W-1:0] w_half_tab [16];
  for (genvar g = 0; g < 16; g++) begin : g_half
    localparam logic [DIV_W-1:0] HALF = half_for(FREQ_HZ[g]);
    assign w_half_tab[g] = HALF;
  end

  logic [DIV_W-1:0] w_half_sh;
  logic [DIV_W-1:0] w_half_eff;
  logic             w_phase_wrap;
  logic             w_unit_wrap;
  logic             w_last_beat;
  logic             w_gap_end;

  assign w_half_sh    = w_half_tab[r_code] >> r_oct;
  // Large octave raises can shift the high notes down to zero; keep at least one cycle.
  assign w_half_eff   = (w_half_sh == '0) ? DIV_W'(1) : w_half_sh;
  assign w_phase_wrap = (r_phase == r_half - 1'b1);
  assign w_unit_wrap  = (r_unit == UNIT_W'(UNIT_LAST));
  assign w_last_beat  = w_unit_wrap && (r_beat == r_dur);
  assign w_gap_end    = (r_gap == GAP_W'(GAP_LAST));

  always_ff @(posedge ext_clk_25m or posedge ext_rst) begin
    if (ext_rst) begin
      r_state <= S_IDLE;
      r_code  <= '0;
      r_oct   <= '0;
      r_dur   <= '0;
      r_half  <= '0;
      r_phase <= '0;
      r_unit  <= '0;
      r_beat  <= '0;
      r_gap   <= '0;
      r_tone  <= 1'b0;
      r_ready <= 1'b1;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_high  <= 1'b0;
      r_cur   <= '0;
    end else begin
      r_done <= 1'b0;
      if (stop) begin
        // Abort wins over everything, including a command offered this cycle.
        r_state <= S_IDLE;
        r_ready <= 1'b1;
        r_busy  <= 1'b0;
        r_tone  <= 1'b0;
        r_cur   <= '0;
        r_high  <= 1'b0;
      end else begin
        case (r_state)
          S_IDLE: begin
            if (in_valid) begin
              r_code  <= in_code;
              r_oct   <= in_oct;
              r_dur   <= in_dur;
              r_ready <= 1'b0;
              r_busy  <= 1'b1;
              r_state <= S_LOAD;
            end
          end
          S_LOAD: begin
            r_half  <= w_half_eff;
            r_phase <= '0;
            r_unit  <= '0;
            r_beat  <= '0;
            r_gap   <= '0;
            r_tone  <= 1'b0;
            r_cur   <= r_code;
            r_high  <= (r_code >= 4'd8) || (r_oct != '0);
            r_state <= S_PLAY;
          end
          S_PLAY: begin
            if (w_phase_wrap) begin
              r_phase <= '0;
              // Rests keep the same timing but never drive the buzzer.
              r_tone  <= (r_code != 4'd0) ? ~r_tone : 1'b0;
            end else begin
              r_phase <= r_phase + 1'b1;
            end
            if (w_unit_wrap) begin
              r_unit <= '0;
              if (!w_last_beat) begin
                r_beat <= r_beat + 1'b1;
              end
            end else begin
              r_unit <= r_unit + 1'b1;
            end
            if (w_last_beat) begin
              r_tone <= 1'b0;
              r_cur  <= '0;
              r_gap  <= '0;
              if (HAS_GAP) begin
                r_state <= S_GAP;
              end else begin
                r_state <= S_IDLE;
                r_ready <= 1'b1;
                r_busy  <= 1'b0;
                r_done  <= 1'b1;
              end
            end
          end
          S_GAP: begin
            if (w_gap_end) begin
              r_state <= S_IDLE;
              r_ready <= 1'b1;
              r_busy  <= 1'b0;
              r_done  <= 1'b1;
            end else begin
              r_gap <= r_gap + 1'b1;
            end
          end
          default: begin
            r_state <= S_IDLE;
            r_ready <= 1'b1;
            r_busy  <= 1'b0;
          end
        endcase
      end
    end
  end

`ifdef TONE_SEQUENCER_VOLUME_EN
  logic [2:0] r_pwm;

  always_ff @(posedge ext_clk_25m or posedge ext_rst) begin
    if (ext_rst) begin
      r_pwm <= '0;
    end else begin
      r_pwm <= r_pwm + 1'b1;
    end
  end

  assign beep = r_tone & (r_pwm < vol);
`else
  assign beep = r_tone;
`endif

  assign in_ready  = r_ready;
  assign cur_code  = r_cur;
  assign high      = r_high;
  assign busy      = r_busy;
  assign note_done = r_done;

endmodule

// File: tb/tb_tone_sequencer.sv
module tb_tone_sequencer;

  localparam int CLK_HZ   = 1_000_000;
  localparam int UNIT_HZ  = 1000;
  localparam int GAP_CYC  = 10;
  localparam int UNIT_CYC = CLK_HZ / UNIT_HZ;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       in_valid = 1'b0;
  logic       in_ready;
  logic [3:0] in_code = '0;
  logic [1:0] in_oct = '0;
  logic [3:0] in_dur = '0;
  logic       stop = 1'b0;
  logic       beep;
  logic [3:0] cur_code;
  logic       high;
  logic       busy;
  logic       note_done;
`ifdef TONE_SEQUENCER_VOLUME_EN
  logic [2:0] vol = 3'd7;
  int unsigned pwm_ticks;
  always @(posedge clk or posedge rst) begin
    if (rst) pwm_ticks <= 0;
    else     pwm_ticks <= pwm_ticks + 1;
  end
`endif

  int total = 0;
  int bad   = 0;

  tone_sequencer #(
    .CLK_HZ (CLK_HZ),
    .UNIT_HZ(UNIT_HZ),
    .DUR_W  (4),
    .OCT_W  (2),
    .GAP_CYC(GAP_CYC),
    .DIV_W  (20)
  ) dut (
    .ext_clk_25m(clk),
    .ext_rst    (rst),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_code    (in_code),
    .in_oct     (in_oct),
    .in_dur     (in_dur),
    .stop       (stop),
`ifdef TONE_SEQUENCER_VOLUME_EN
    .vol        (vol),
`endif
    .beep       (beep),
    .cur_code   (cur_code),
    .high       (high),
    .busy       (busy),
    .note_done  (note_done)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached, total=%0d bad=%0d", total, bad);
    $fatal(1);
  end

  // Reference: musical frequency table and tone shape derived from it.
  int freq_tab [16] = '{0, 262, 294, 330, 349, 392, 440, 494,
                        523, 587, 659, 698, 784, 880, 988, 1047};

  function automatic int model_half(input int c, input int o);
    int h;
    if (c == 0) return 1;
    h = (CLK_HZ / (2 * freq_tab[c])) >> o;
    return (h < 1) ? 1 : h;
  endfunction

  // Tone level k cycles into the note: low for the first half-period, then alternating.
  function automatic bit model_tone(input int c, input int o, input int k);
    if (c == 0) return 1'b0;
    return ((k / model_half(c, o)) % 2) == 1;
  endfunction

  // Observations gathered by do_note for the scenario tasks to judge.
  int         m_wait, m_beep_err, m_code_err, m_high_err, m_busy_err, m_gap_err;
  int         m_high_cnt, m_rise, m_fall, m_cycles;
  logic       m_load_bad, m_high_first;
  logic [7:0] m_end_vec;

  task automatic do_note(input logic [3:0] c, input logic [1:0] o, input logic [3:0] d,
                         input bit hold);
    int  len;
    bit  exp_b;
    bit  exp_high;
    m_beep_err = 0; m_code_err = 0; m_high_err = 0; m_busy_err = 0; m_gap_err = 0;
    m_high_cnt = 0; m_rise = -1; m_fall = -1; m_cycles = 0; m_wait = 0;
    m_load_bad = 1'b1; m_high_first = 1'bx; m_end_vec = 'x;
    exp_high = (c >= 8) || (o != 0);
    in_code = c; in_oct = o; in_dur = d; in_valid = 1'b1;
    while (in_ready !== 1'b1 && m_wait < 5000) begin
      @(negedge clk);
      m_wait++;
    end
    if (in_ready !== 1'b1) begin
      in_valid = 1'b0;
      return;
    end
    @(negedge clk);
    if (!hold) in_valid = 1'b0;
    m_cycles = 1;
    m_load_bad = (busy !== 1'b1) || (in_ready !== 1'b0) || (beep !== 1'b0) || (note_done !== 1'b0);
    len = (int'(d) + 1) * UNIT_CYC;
    for (int k = 0; k < len; k++) begin
      @(negedge clk);
      m_cycles++;
      exp_b = model_tone(c, o, k);
`ifdef TONE_SEQUENCER_VOLUME_EN
      exp_b = exp_b && ((pwm_ticks % 8) < vol);
`endif
      if (k == 0) m_high_first = high;
      if (beep !== exp_b) m_beep_err++;
      if (beep === 1'b1) m_high_cnt++;
      if (m_rise < 0 && beep === 1'b1) m_rise = k;
      if (m_rise >= 0 && m_fall < 0 && beep === 1'b0) m_fall = k;
      if (cur_code !== c) m_code_err++;
      if (high !== exp_high) m_high_err++;
      if (busy !== 1'b1 || in_ready !== 1'b0 || note_done !== 1'b0) m_busy_err++;
    end
    for (int k = 0; k < GAP_CYC; k++) begin
      @(negedge clk);
      m_cycles++;
      if (beep !== 1'b0 || cur_code !== 4'd0 || busy !== 1'b1 || note_done !== 1'b0 ||
          high !== exp_high) m_gap_err++;
    end
    @(negedge clk);
    m_cycles++;
    m_end_vec = {note_done, busy, in_ready, beep, cur_code};
  endtask

  task automatic test_reset();
    #23;
    total++;
    if ({in_ready, busy, beep, cur_code, high, note_done} !== 9'b1_0_0_0000_0_0) begin
      bad++;
      $display("FAIL reset_hold: outputs %b, want 100000000",
               {in_ready, busy, beep, cur_code, high, note_done});
    end
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    total++;
    if ({in_ready, busy, beep, cur_code, high, note_done} !== 9'b1_0_0_0000_0_0) begin
      bad++;
      $display("FAIL reset_release: outputs %b, want 100000000",
               {in_ready, busy, beep, cur_code, high, note_done});
    end
  endtask

  task automatic test_basic();
    do_note(4'd6, 2'd0, 4'd1, 1'b0);
    total++; if (m_wait !== 0) begin bad++; $display("FAIL basic_accept: waited %0d, want 0", m_wait); end
    total++; if (m_load_bad !== 1'b0) begin bad++; $display("FAIL basic_load: bad=%b, want 0", m_load_bad); end
`ifndef TONE_SEQUENCER_VOLUME_EN
    total++; if (m_rise !== 1136) begin bad++; $display("FAIL basic_half: first toggle at %0d, want 1136", m_rise); end
`endif
    total++; if (m_beep_err !== 0) begin bad++; $display("FAIL basic_beep: %0d bad cycles, want 0", m_beep_err); end
    total++; if (m_code_err !== 0) begin bad++; $display("FAIL basic_code: %0d bad cycles, want 0", m_code_err); end
    total++; if (m_high_err !== 0) begin bad++; $display("FAIL basic_high: %0d bad cycles, want 0", m_high_err); end
    total++; if (m_busy_err !== 0) begin bad++; $display("FAIL basic_busy: %0d bad cycles, want 0", m_busy_err); end
    total++; if (m_gap_err !== 0) begin bad++; $display("FAIL basic_gap: %0d bad cycles, want 0", m_gap_err); end
    total++; if (m_end_vec !== 8'b1010_0000) begin bad++; $display("FAIL basic_done: %b, want 10100000", m_end_vec); end
    total++; if (m_cycles !== 2012) begin bad++; $display("FAIL basic_latency: %0d cycles, want 2012", m_cycles); end
  endtask

  task automatic test_octave();
    logic [3:0] codes [2] = '{4'd13, 4'd6};
    logic [1:0] octs  [2] = '{2'd0, 2'd1};
    for (int i = 0; i < 2; i++) begin
      do_note(codes[i], octs[i], 4'd1, 1'b0);
`ifndef TONE_SEQUENCER_VOLUME_EN
      total++; if (m_rise !== 568) begin bad++; $display("FAIL oct_rise[%0d]: %0d, want 568", i, m_rise); end
      total++; if (m_fall - m_rise !== 568) begin bad++; $display("FAIL oct_half[%0d]: %0d, want 568", i, m_fall - m_rise); end
`endif
      total++; if (m_high_first !== 1'b1) begin bad++; $display("FAIL oct_high[%0d]: %b, want 1", i, m_high_first); end
      total++; if (m_code_err !== 0) begin bad++; $display("FAIL oct_code[%0d]: %0d bad cycles, want 0", i, m_code_err); end
      total++; if (m_beep_err !== 0) begin bad++; $display("FAIL oct_beep[%0d]: %0d bad cycles, want 0", i, m_beep_err); end
    end
  endtask

  task automatic test_rest();
    do_note(4'd0, 2'd0, 4'd2, 1'b0);
    total++; if (m_high_cnt !== 0) begin bad++; $display("FAIL rest_beep: %0d high cycles, want 0", m_high_cnt); end
    total++; if (m_busy_err !== 0) begin bad++; $display("FAIL rest_busy: %0d bad cycles, want 0", m_busy_err); end
    total++; if (m_high_err !== 0) begin bad++; $display("FAIL rest_high: %0d bad cycles, want 0", m_high_err); end
    total++; if (m_end_vec !== 8'b1010_0000) begin bad++; $display("FAIL rest_done: %b, want 10100000", m_end_vec); end
    total++; if (m_cycles !== 3012) begin bad++; $display("FAIL rest_latency: %0d cycles, want 3012", m_cycles); end
  endtask

  task automatic test_back_to_back();
    logic [3:0] codes [3] = '{4'd1, 4'd8, 4'd15};
    int halves [3] = '{1908, 956, 477};
    for (int i = 0; i < 3; i++) begin
      do_note(codes[i], 2'd0, 4'd1, 1'b1);
      total++; if (m_wait !== 0) begin bad++; $display("FAIL b2b_wait[%0d]: %0d, want 0", i, m_wait); end
      total++; if (m_load_bad !== 1'b0) begin bad++; $display("FAIL b2b_load[%0d]: %b, want 0", i, m_load_bad); end
`ifndef TONE_SEQUENCER_VOLUME_EN
      total++; if (m_rise !== halves[i]) begin bad++; $display("FAIL b2b_half[%0d]: %0d, want %0d", i, m_rise, halves[i]); end
`endif
      total++; if (m_beep_err !== 0) begin bad++; $display("FAIL b2b_beep[%0d]: %0d bad cycles, want 0", i, m_beep_err); end
      total++; if (m_end_vec !== 8'b1010_0000) begin bad++; $display("FAIL b2b_done[%0d]: %b, want 10100000", i, m_end_vec); end
    end
    in_valid = 1'b0;
    @(negedge clk);
    total++; if ({busy, note_done} !== 2'b00) begin bad++; $display("FAIL b2b_idle: busy,done=%b, want 00", {busy, note_done}); end
  endtask

  task automatic test_stop();
    int w = 0;
    int dn = 0;
    int bz = 0;
    in_code = 4'd6; in_oct = 2'd0; in_dur = 4'd3; in_valid = 1'b1;
    while (in_ready !== 1'b1 && w < 100) begin @(negedge clk); w++; end
    @(negedge clk);
    in_valid = 1'b0;
    repeat (1200) @(negedge clk);
`ifndef TONE_SEQUENCER_VOLUME_EN
    total++; if (beep !== model_tone(6, 0, 1199)) begin bad++; $display("FAIL stop_pre: beep=%b, want %b", beep, model_tone(6, 0, 1199)); end
`endif
    stop = 1'b1;
    @(negedge clk);
    total++;
    if ({beep, busy, in_ready, cur_code, high} !== 8'b0_0_1_0000_0) begin
      bad++; $display("FAIL stop_abort: %b, want 00100000", {beep, busy, in_ready, cur_code, high});
    end
    in_code = 4'd8; in_valid = 1'b1;
    @(negedge clk);
    total++; if ({busy, in_ready} !== 2'b01) begin bad++; $display("FAIL stop_priority: busy,ready=%b, want 01", {busy, in_ready}); end
    stop = 1'b0; in_valid = 1'b0;
    repeat (4500) begin
      @(negedge clk);
      if (note_done === 1'b1) dn++;
      if (busy !== 1'b0) bz++;
    end
    total++; if (dn !== 0) begin bad++; $display("FAIL stop_no_done: %0d pulses, want 0", dn); end
    total++; if (bz !== 0) begin bad++; $display("FAIL stop_stays_idle: %0d busy cycles, want 0", bz); end
  endtask

  task automatic test_reset_gap();
    int w = 0;
    int dn = 0;
    in_code = 4'd13; in_oct = 2'd0; in_dur = 4'd0; in_valid = 1'b1;
    while (in_ready !== 1'b1 && w < 100) begin @(negedge clk); w++; end
    @(negedge clk);
    in_valid = 1'b0;
    repeat (UNIT_CYC + 4) @(negedge clk);
    total++;
    if ({busy, cur_code, high} !== 6'b1_0000_1) begin
      bad++; $display("FAIL rgap_in_gap: busy,code,high=%b, want 100001", {busy, cur_code, high});
    end
    #3 rst = 1'b1;
    #1;
    total++;
    if ({beep, busy, in_ready, cur_code, high, note_done} !== 9'b0_0_1_0000_0_0) begin
      bad++; $display("FAIL rgap_async: %b, want 001000000", {beep, busy, in_ready, cur_code, high, note_done});
    end
    @(negedge clk);
    rst = 1'b0;
    repeat (40) begin
      @(negedge clk);
      if (note_done === 1'b1 || busy !== 1'b0) dn++;
    end
    total++; if (dn !== 0) begin bad++; $display("FAIL rgap_no_done: %0d bad cycles, want 0", dn); end
  endtask

  task automatic test_random();
    logic [3:0] c, d;
    logic [1:0] o;
    for (int i = 0; i < 8; i++) begin
      repeat ($urandom_range(0, 3)) @(negedge clk);
      c = 4'($urandom_range(0, 15));
      o = 2'($urandom_range(0, 3));
      d = 4'($urandom_range(0, 2));
      do_note(c, o, d, 1'b0);
      total++; if (m_beep_err !== 0) begin bad++; $display("FAIL rnd_beep[%0d] c=%0d o=%0d: %0d bad cycles, want 0", i, c, o, m_beep_err); end
      total++; if (m_code_err !== 0) begin bad++; $display("FAIL rnd_code[%0d]: %0d bad cycles, want 0", i, m_code_err); end
      total++; if (m_high_err !== 0) begin bad++; $display("FAIL rnd_high[%0d]: %0d bad cycles, want 0", i, m_high_err); end
      total++; if (m_busy_err !== 0) begin bad++; $display("FAIL rnd_busy[%0d]: %0d bad cycles, want 0", i, m_busy_err); end
      total++; if (m_gap_err !== 0) begin bad++; $display("FAIL rnd_gap[%0d]: %0d bad cycles, want 0", i, m_gap_err); end
      total++; if (m_end_vec !== 8'b1010_0000) begin bad++; $display("FAIL rnd_done[%0d]: %b, want 10100000", i, m_end_vec); end
      total++;
      if (m_cycles !== 2 + (int'(d) + 1) * UNIT_CYC + GAP_CYC) begin
        bad++; $display("FAIL rnd_len[%0d]: %0d, want %0d", i, m_cycles, 2 + (int'(d) + 1) * UNIT_CYC + GAP_CYC);
      end
    end
  endtask

`ifdef TONE_SEQUENCER_VOLUME_EN
  task automatic test_volume();
    vol = 3'd0;
    do_note(4'd6, 2'd0, 4'd1, 1'b0);
    total++; if (m_high_cnt !== 0) begin bad++; $display("FAIL vol_mute: %0d high cycles, want 0", m_high_cnt); end
    vol = 3'd4;
    do_note(4'd6, 2'd0, 4'd1, 1'b0);
    total++; if (m_beep_err !== 0) begin bad++; $display("FAIL vol_half: %0d bad cycles, want 0", m_beep_err); end
    total++; if (m_high_cnt < 400 || m_high_cnt > 440) begin bad++; $display("FAIL vol_duty: %0d high cycles, want about 432", m_high_cnt); end
    vol = 3'd7;
  endtask
`endif

  initial begin
    test_reset();
    test_basic();
    test_octave();
    test_rest();
    test_back_to_back();
    test_stop();
    test_reset_gap();
    test_random();
`ifdef TONE_SEQUENCER_VOLUME_EN
    test_volume();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/tone_sequencer.md
Name: tone_sequencer

Overview:
- Parametrised successor to the single-note buzzer player.
- Accepts timed note commands (code, octave shift, duration) over a valid/ready handshake from the ROM reader or keyboard front end.
- Generates the square-wave tone directly from the system clock, times each note, inserts an articulation gap, then requests the next note.
- Exposes the current code and high-octave flag for the 7-segment/LED display logic.

Parameters:
- CLK_HZ, 25_000_000, system clock frequency in Hz.
- UNIT_HZ, 16, duration units per second; unit length = CLK_HZ/UNIT_HZ clocks (integer floor).
- DUR_W, 4, width of the duration field; a note lasts dur+1 units.
- OCT_W, 2, width of the octave-shift field.
- GAP_CYC, 250_000, silent clocks appended after every note (0 = no gap).
- DIV_W, 20, width of the half-period counter; must hold CLK_HZ/524.

Ports:
- ext_clk_25m, input, 1, system clock.
- ext_rst, input, 1, asynchronous active-high reset.
- in_valid, input, 1, note command valid.
- in_ready, output, 1, block can accept a command.
- in_code, input, 4, note code: 0 = rest; 1..15 per the frequency table.
- in_oct, input, OCT_W, octave raise; half-period is shifted right by in_oct.
- in_dur, input, DUR_W, duration minus one, in units.
- stop, input, 1, synchronous abort.
- beep, output, 1, buzzer drive.
- cur_code, output, 4, code currently sounding (0 when idle or in gap).
- high, output, 1, high when cur_code>=8 or latched oct>0.
- busy, output, 1, high in LOAD, PLAY or GAP.
- note_done, output, 1, one-cycle pulse when a note (including its gap) completes.

Behaviour:
- Frequency table, codes 1..15, in Hz: 262 294 330 349 392 440 494 523 587 659 698 784 880 988 1047.
- half[c] = floor(CLK_HZ/(2*f)), computed at elaboration.
- Effective half-period: h = half[c] >> oct, clamped to a minimum of 1.
- Reset (asynchronous): state IDLE; all counters 0; beep=0, cur_code=0, high=0, busy=0, note_done=0, in_ready=1 from the first clock.
- States: IDLE -> LOAD -> PLAY -> GAP -> IDLE.
- IDLE:
  - in_ready=1.
  - If in_valid=1, latch code/oct/dur and go to LOAD. Command is accepted on the edge where valid&&ready.
- LOAD:
  - One cycle. in_ready=0.
  - Compute h, clear the phase counter and unit counters, set beep=0.
  - Update cur_code and high.
  - Go to PLAY.
- PLAY:
  - Phase counter counts 0..h-1; at h-1 it wraps to 0 and beep toggles. First toggle occurs h cycles after PLAY entry.
  - Code 0 (rest): beep held 0; timing runs identically.
  - Unit counter counts 0..CLK_HZ/UNIT_HZ-1. Beat counter increments on each unit wrap.
  - When the beat counter reaches dur on a unit wrap, go to GAP. PLAY length is exactly (dur+1)*(CLK_HZ/UNIT_HZ) cycles.
- GAP:
  - beep=0, cur_code=0; high keeps the latched value.
  - Lasts GAP_CYC cycles, then go to IDLE and assert note_done for one cycle.
  - GAP_CYC=0: go directly from PLAY to IDLE.
- stop=1 in any state: next state IDLE, beep=0, cur_code=0, high=0. note_done is not pulsed.
- stop has priority over in_valid in the same cycle: the command is not accepted.
- Back-to-back commands: a new command is accepted in the first IDLE cycle, so there is exactly one IDLE cycle between notes.
- Commands presented while not ready are held by the source; none are dropped.
- All counters are unsigned and wrap-free by construction; no arithmetic overflow is possible for legal parameters.

Optional Feature:
- Macro: TONE_SEQUENCER_VOLUME_EN.
- When defined:
  - Adds port vol (input, 3 bits).
  - Adds a free-running 3-bit PWM counter.
  - beep output = tone & (pwm_cnt < vol), with the counter stepping at the clock rate. vol=0 mutes; vol=7 gives 7/8 duty within each high half.
  - The PWM counter resets to 0.
- When not defined: no vol port; beep is the raw tone.

Test Plan:
- Parameters for all scenarios unless noted: CLK_HZ=1_000_000, UNIT_HZ=1000, GAP_CYC=10.
- Code 6, oct 0, dur 1:
  - beep toggles every 1136 cycles.
  - PLAY lasts 2000 cycles; beep=0 for 10 gap cycles; note_done pulses exactly once.
  - Total from accept to note_done is 2012 cycles ±1.
- Code 13 vs code 6 with oct 1: both produce a 568-cycle half-period. high=1 in both cases. cur_code is 13 and 6 respectively.
- Code 0, dur 2:
  - beep stays 0 for the full 3000 cycles.
  - busy=1 throughout, then note_done pulses.
- Back-to-back burst of codes 1, 8, 15 with in_valid held high:
  - Three accepts, each separated by exactly one IDLE cycle.
  - Half-periods are 1908, 956 and 477.
- Assert stop mid-PLAY, and separately assert ext_rst asynchronously mid-GAP:
  - beep=0, busy=0, in_ready=1 by the next edge (immediately for reset).
  - No note_done pulse.
- With TONE_SEQUENCER_VOLUME_EN, code 6, vol=0: beep is never high. With vol=4: beep is high 4 of every 8 cycles during tone-high phases.
